truth_table_scanner: RTL and testbench

- Sequential stimulus-and-capture stage sitting directly upstream of a combinational N-input Boolean function (default 3 inputs x, y, z).
- On `start`, walks the input vector through all 2^N combinations in ascending order, holding each for a fixed settle window, and samples the function's single output into a truth-table register.
- Compares the captured table against an expected mask and reports a mismatch count and pass flag.
- Replaces hand-written per-vector stimulus with a self-checking hardware scan.

---
 rtl/truth_table_scanner.sv | 99 +++++++++
 tb/tb_truth_table_scanner.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: walks an N_IN-bit input vector through every
// combination in ascending order, holds each for SETTLE cycles, captures the
// downstream combinational function's output into a truth-table register and
// scores it against an expected table latched at start.
//
// Legal parameter ranges: N_IN 1..6, SETTLE 1..15 (the settle counter is
// 4 bits wide, so larger SETTLE values would be truncated).
module truth_table_scanner #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      vec_out,
  input  logic                 s_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic [N_IN:0]        mismatch_cnt,
  output logic                 pass
);

  localparam int NV = 2**N_IN;
  localparam int CW = 4;
  localparam logic [CW-1:0]   SETTLE_C = CW'(SETTLE);
  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;     // cycles left in the current vector's window
  logic [NV-1:0]   exp_q;   // expected table frozen for the whole scan
  logic            miss;    // current sample disagrees with the expected bit

  assign miss = s_in ^ exp_q[vec_out];

  // Scan sequencer: all outputs are registered here. A sample is taken on the
  // last cycle of each settle window (cnt==1), so vector i is sampled at the
  // edge closing cycle (i+1)*SETTLE counted from the start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      exp_q        <= '0;
      vec_out      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      table_out    <= '0;
      mismatch_cnt <= '0;
      pass         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // vec_out keeps its last value here; it is only rewound on start.
          if (start) begin
            state        <= SCAN;
            vec_out      <= '0;
            cnt          <= SETTLE_C;
            table_out    <= '0;
            mismatch_cnt <= '0;
            pass         <= 1'b0;
            exp_q        <= expected;
            busy         <= 1'b1;
          end
        end
        SCAN: begin
          if (cnt == CW'(1)) begin
            table_out[vec_out] <= s_in;
            if (miss) mismatch_cnt <= mismatch_cnt + (N_IN+1)'(1);
            if (vec_out == LAST_VEC) begin
              state <= FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              vec_out <= vec_out + N_IN'(1);
              cnt     <= SETTLE_C;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        FINISH: begin
          // mismatch_cnt is final by now; start is deliberately not looked at.
          pass  <= (mismatch_cnt == '0);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: two instances (SETTLE=1 and SETTLE=3) drive
// a real s = (~x|y)&~(~y|z) or a constant 1. Table rows cover full scans;
// hand sequences cover ignored starts, restart and mid-scan reset.
module tb_truth_table_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, tie1, sel3;
  logic [7:0] expected;
  logic [2:0] vec1, vec3, vec;
  logic       s1, s3, busy1, busy3, done1, done3, pass1, pass3;
  logic [7:0] tab1, tab3, tab;
  logic [3:0] mm1, mm3, mm;
  logic       busy, done, pass;

  function automatic logic fn(input logic [2:0] v);
    logic x, y, z;
    x = v[2]; y = v[1]; z = v[0];
    return (~x | y) & ~(~y | z);
  endfunction

  assign s1 = tie1 ? 1'b1 : fn(vec1);
  assign s3 = tie1 ? 1'b1 : fn(vec3);

  assign vec  = sel3 ? vec3  : vec1;
  assign busy = sel3 ? busy3 : busy1;
  assign done = sel3 ? done3 : done1;
  assign tab  = sel3 ? tab3  : tab1;
  assign mm   = sel3 ? mm3   : mm1;
  assign pass = sel3 ? pass3 : pass1;

  truth_table_scanner #(.N_IN(3), .SETTLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel3), .expected(expected),
    .vec_out(vec1), .s_in(s1), .busy(busy1), .done(done1),
    .table_out(tab1), .mismatch_cnt(mm1), .pass(pass1));

  truth_table_scanner #(.N_IN(3), .SETTLE(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start & sel3), .expected(expected),
    .vec_out(vec3), .s_in(s3), .busy(busy3), .done(done3),
    .table_out(tab3), .mismatch_cnt(mm3), .pass(pass3));

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] tab;
    logic [3:0] mm;
    logic       ps;
  } res_t;

  typedef struct {
    bit         s3;
    logic [7:0] ex;
    bit         t1;
    res_t       want;
  } row_t;

  res_t sbq[$];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One full scan; expected is scrambled after the start edge to prove it
  // was latched. Checks every cycle up to two past done.
  task automatic do_scan(input row_t r);
    int   s, last;
    res_t got;
    s    = r.s3 ? 3 : 1;
    last = 8 * s;
    got  = '{tab: 8'h00, mm: 4'h0, ps: 1'b0};
    sel3 = r.s3; tie1 = r.t1; expected = r.ex; start = 1'b1;
    sbq.push_back(r.want);
    tick();
    start = 1'b0; expected = ~r.ex;
    for (int c = 1; c <= last + 1; c++) begin
      if (c <= last) begin
        chk("busy", 32'(busy), 32'd1);
        chk("vec", 32'(vec), 32'((c - 1) / s));
        chk("done_low", 32'(done), 32'd0);
      end else begin
        chk("busy_end", 32'(busy), 32'd0);
        chk("done_pulse", 32'(done), 32'd1);
        if (sbq.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          got = sbq.pop_front();
          chk("table", 32'(tab), 32'(got.tab));
          chk("mismatch", 32'(mm), 32'(got.mm));
        end
        chk("vec_hold", 32'(vec), 32'd7);
      end
      tick();
    end
    chk("done_clear", 32'(done), 32'd0);
    chk("pass", 32'(pass), 32'(got.ps));
    chk("table_hold", 32'(tab), 32'(got.tab));
    tick();
  endtask

  row_t rows[6];

  initial begin
    rows[0] = '{s3: 1'b0, ex: 8'h44, t1: 1'b0, want: '{tab: 8'h44, mm: 4'd0, ps: 1'b1}};
    rows[1] = '{s3: 1'b0, ex: 8'h45, t1: 1'b0, want: '{tab: 8'h44, mm: 4'd1, ps: 1'b0}};
    rows[2] = '{s3: 1'b0, ex: 8'h00, t1: 1'b1, want: '{tab: 8'hFF, mm: 4'd8, ps: 1'b0}};
    rows[3] = '{s3: 1'b1, ex: 8'h44, t1: 1'b0, want: '{tab: 8'h44, mm: 4'd0, ps: 1'b1}};
    rows[4] = '{s3: 1'b0, ex: 8'hBB, t1: 1'b0, want: '{tab: 8'h44, mm: 4'd8, ps: 1'b0}};
    rows[5] = '{s3: 1'b1, ex: 8'h00, t1: 1'b1, want: '{tab: 8'hFF, mm: 4'd8, ps: 1'b0}};

    rst_n = 1'b0; start = 1'b0; tie1 = 1'b0; sel3 = 1'b0; expected = 8'h00;
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      sel3 = (k == 1);
      #0;
      chk("rst_vec", 32'(vec), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_table", 32'(tab), 32'd0);
      chk("rst_mm", 32'(mm), 32'd0);
      chk("rst_pass", 32'(pass), 32'd0);
    end
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) do_scan(rows[i]);

    // Starts during SCAN (cycle 4) and FINISH (cycle 9) are ignored; a start
    // in cycle 10 launches a fresh scan with cleared results.
    sel3 = 1'b0; tie1 = 1'b0; expected = 8'h44; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c <= 8) begin
        chk("ig_vec", 32'(vec), 32'(c - 1));
        chk("ig_busy", 32'(busy), 32'd1);
      end
      if (c >= 11 && c <= 18) chk("rs_vec", 32'(vec), 32'(c - 11));
      chk("ig_done", 32'(done), 32'((c == 9) || (c == 19)));
      if (c == 9)  chk("ig_table", 32'(tab), 32'h44);
      if (c == 10) begin
        chk("ig_busy10", 32'(busy), 32'd0);
        chk("ig_pass", 32'(pass), 32'd1);
      end
      if (c == 11) begin
        chk("rs_table_clr", 32'(tab), 32'd0);
        chk("rs_mm_clr", 32'(mm), 32'd0);
        chk("rs_pass_clr", 32'(pass), 32'd0);
        chk("rs_busy", 32'(busy), 32'd1);
      end
      if (c == 19) chk("rs_table", 32'(tab), 32'h44);
      if (c == 20) chk("rs_pass", 32'(pass), 32'd1);
      start = (c == 4) || (c == 9) || (c == 10);
      tick();
    end
    start = 1'b0;
    tick();

    // Reset asserted during cycle 5 aborts the scan and clears everything.
    expected = 8'h44; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 5) rst_n = 1'b0;
      if (c == 6) begin
        rst_n = 1'b1;
        chk("ab_vec", 32'(vec), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        chk("ab_table", 32'(tab), 32'd0);
        chk("ab_mm", 32'(mm), 32'd0);
        chk("ab_pass", 32'(pass), 32'd0);
      end
      if (c >= 7) begin
        chk("ab_idle_busy", 32'(busy), 32'd0);
        chk("ab_idle_done", 32'(done), 32'd0);
      end
      tick();
    end
    do_scan(rows[0]);

    if (sbq.size() != 0) chk("sb_leftover", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
